// File: rtl/syzygy_adc_pkg.sv
// Shared definitions for the SYZYGY ADC capture block: FSM states,
// half-word/word widths and the two-samples-per-word packing layout.
package syzygy_adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  // Each sample is sign-extended to a half-word; two half-words per pipe word.
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;
  localparam int LO_LSB = 0;
  localparam int HI_LSB = HALF_W;

  // Even-indexed sample in the low half, odd-indexed sample in the high half.
  function automatic logic [WORD_W-1:0] pack_word(input logic [HALF_W-1:0] lo,
                                                  input logic [HALF_W-1:0] hi);
    logic [WORD_W-1:0] w;
    w = '0;
    w[LO_LSB +: HALF_W] = lo;
    w[HI_LSB +: HALF_W] = hi;
    return w;
  endfunction

endpackage

// File: rtl/syzygy_adc_fifo.sv
// Synchronous first-word-fall-through FIFO. A pop frees a slot in the same
// cycle, so a push into a full FIFO succeeds when it coincides with a pop.
module syzygy_adc_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // Empty FIFO presents zero rather than stale storage.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/syzygy_adc_capture.sv
// SYZYGY ADC receive path: two-stage sample pipeline with format conversion,
// immediate/threshold trigger, counted capture packed two samples per word
// into an output FIFO drained over a valid/ready stream.
module syzygy_adc_capture
  import syzygy_adc_pkg::*;
#(
  parameter int ADC_WIDTH   = 12,
  parameter int DATA_FORMAT = 1,
  parameter int FIFO_DEPTH  = 512,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADC_WIDTH-1:0]          adc_data,
  input  logic                          arm,
  input  logic                          abort,
  input  logic                          trigger_mode,
  input  logic [ADC_WIDTH-1:0]          threshold,
  input  logic [CNT_WIDTH-1:0]          sample_count,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic [WORD_W-1:0]             dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  // Offset binary becomes two's complement by flipping the MSB.
  function automatic logic signed [ADC_WIDTH-1:0] fmt_conv(input logic [ADC_WIDTH-1:0] raw);
    logic [ADC_WIDTH-1:0] r;
    r = raw;
    if (DATA_FORMAT == 1) r[ADC_WIDTH-1] = ~raw[ADC_WIDTH-1];
    return $signed(r);
  endfunction

  function automatic logic [HALF_W-1:0] sext_half(input logic signed [ADC_WIDTH-1:0] v);
    logic signed [HALF_W-1:0] t;
    t = v;
    return t;
  endfunction

  logic [ADC_WIDTH-1:0]        adc_q;
  logic signed [ADC_WIDTH-1:0] s_q, p_q, thr_q, thr_d;
  state_t                      state_q, state_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d, idx_q, idx_d;
  logic                        mode_q, mode_d;
  logic [HALF_W-1:0]           lo_q, lo_d;
  logic                        wr_q, wr_d, last_q, last_d;
  logic [WORD_W-1:0]           wdata_q, wdata_d;
  logic                        done_q, done_d, ovf_q, ovf_d;
  logic                        fifo_full, fifo_empty, pop, trig, take;

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign dout_valid = !fifo_empty;
  assign pop        = dout_valid && dout_ready;

  // Stage 1 registers the raw bus; stage 2 holds converted sample s and previous p.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adc_q <= '0;
      s_q   <= '0;
      p_q   <= '0;
    end else begin
      adc_q <= adc_data;
      s_q   <= fmt_conv(adc_q);
      p_q   <= s_q;
    end
  end

  // Capture FSM, packer and control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      thr_q   <= '0;
      lo_q    <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      thr_q   <= thr_d;
      lo_q    <= lo_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state: trigger qualification, sample counting and word assembly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    thr_d   = thr_q;
    lo_d    = lo_q;
    wr_d    = 1'b0;
    wdata_d = wdata_q;
    last_d  = 1'b0;
    done_d  = last_q;
    ovf_d   = ovf_q;
    take    = 1'b0;
    trig    = mode_q ? ((p_q < thr_q) && (s_q >= thr_q)) : 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (arm && !abort) begin
          state_d = ST_ARMED;
          cnt_d   = sample_count;
          mode_d  = trigger_mode;
          thr_d   = $signed(threshold);
          idx_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_ARMED: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (trig) begin
          take = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (abort) state_d = ST_IDLE;
        else       take    = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (take) begin
      if (!idx_q[0]) begin
        lo_d = sext_half(s_q);
      end else begin
        wr_d    = 1'b1;
        wdata_d = pack_word(lo_q, sext_half(s_q));
      end
      if (idx_q == cnt_q - 1'b1) begin
        // An odd-length capture flushes its last sample with a zero high half.
        if (!idx_q[0]) begin
          wr_d    = 1'b1;
          wdata_d = pack_word(sext_half(s_q), '0);
        end
        last_d  = 1'b1;
        state_d = ST_IDLE;
      end else begin
        state_d = ST_CAPTURE;
        idx_d   = idx_q + 1'b1;
      end
    end

    // A drop on a full FIFO wins over the clear from a coincident arm.
    if (wr_q && fifo_full && !pop) ovf_d = 1'b1;
  end

  syzygy_adc_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr_q),
    .wdata_i (wdata_q),
    .pop_i   (dout_ready),
    .rdata_o (dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

endmodule
